// File: rtl/obstacle_spawner.sv
// Two-slot obstacle spawner for the runner game.
// Each slot scrolls left on every advance (run && step), parks at X_PARK once it
// leaves the left edge, waits a pseudo-random gap, then respawns at X_SPAWN with
// a pseudo-random height, provided the other slot is far enough away.
// Handshake: none -- step is a qualified strobe, acted on only when run is high;
// every output is a register, so an event sampled at edge n shows after edge n.
module obstacle_spawner #(
  parameter int          X_SPAWN   = 160,
  parameter int          X_PARK    = 255,
  parameter int          MIN_H     = 7,
  parameter int          H_BITS    = 3,
  parameter int          MIN_GAP   = 40,
  parameter int          GAP_BITS  = 6,
  parameter int          MIN_SEP   = 48,
  parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       clear,
  input  logic       run,
  input  logic       step,
  output logic [7:0] obs1X,
  output logic [7:0] obs1H,
  output logic [7:0] obs2X,
  output logic [7:0] obs2H,
  output logic [1:0] obs_active,
  output logic [1:0] spawn_pulse
);

  typedef enum logic {
    ST_GAP    = 1'b0,
    ST_ACTIVE = 1'b1
  } slot_state_e;

  localparam logic [15:0] LFSR_MASK = 16'hB400;
  localparam logic [7:0]  X1_INIT   = 8'd120;
  localparam logic [7:0]  H1_INIT   = 8'd7;
  localparam logic [7:0]  X2_INIT   = 8'd254;
  localparam logic [7:0]  H2_INIT   = 8'd14;
  localparam logic [7:0]  X_SPAWN_V = 8'(X_SPAWN);
  localparam logic [7:0]  X_PARK_V  = 8'(X_PARK);
  localparam logic [7:0]  MIN_H_V   = 8'(MIN_H);
  localparam logic [7:0]  MIN_GAP_V = 8'(MIN_GAP);
  // An active slot strictly right of this X blocks the other slot's spawn.
  localparam logic [7:0]  SEP_LIMIT = 8'(X_SPAWN - MIN_SEP);

  logic [15:0]           lfsr_q, lfsr_d;
  logic [1:0][7:0]       x_q, x_d;
  logic [1:0][7:0]       h_q, h_d;
  logic [1:0][7:0]       cnt_q, cnt_d;
  slot_state_e [1:0]     st_q, st_d;
  logic [1:0]            pulse_q, pulse_d;

  logic       advance;
  logic       blk_by0;
  logic       blk_by1;
  logic       spawn0_now;
  logic [1:0] spawn_ok;
  logic [7:0] gap_val;
  logic [7:0] h_val;

  // Next-state logic: LFSR free-runs; slots move only on an advance cycle.
  always_comb begin
    lfsr_d  = {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? LFSR_MASK : 16'h0000);
    x_d     = x_q;
    h_d     = h_q;
    cnt_d   = cnt_q;
    st_d    = st_q;
    pulse_d = 2'b00;

    advance = run && step;
    // Gap and height draw from the pre-shift LFSR value of this cycle.
    gap_val = MIN_GAP_V + 8'(lfsr_q[GAP_BITS+7:8]);
    h_val   = MIN_H_V + 8'(lfsr_q[H_BITS-1:0]);

    blk_by0 = (st_q[0] == ST_ACTIVE) && (x_q[0] > SEP_LIMIT);
    blk_by1 = (st_q[1] == ST_ACTIVE) && (x_q[1] > SEP_LIMIT);

    // Slot 1 has priority; it sees slot 2 as it stands before this advance.
    spawn_ok[0] = !blk_by1;
    spawn0_now  = advance && (st_q[0] == ST_GAP) && (cnt_q[0] == 8'd0) && spawn_ok[0];
    // Slot 2 sees slot 1 after a same-cycle spawn (X_SPAWN, always blocking).
    spawn_ok[1] = !spawn0_now && !blk_by0;

    if (advance) begin
      for (int i = 0; i < 2; i++) begin
        case (st_q[i])
          ST_ACTIVE: begin
            if (x_q[i] == 8'd0) begin
              st_d[i]  = ST_GAP;
              x_d[i]   = X_PARK_V;
              cnt_d[i] = gap_val;
            end else begin
              x_d[i] = x_q[i] - 8'd1;
            end
          end
          default: begin
            if (cnt_q[i] != 8'd0) begin
              cnt_d[i] = cnt_q[i] - 8'd1;
            end else if (spawn_ok[i]) begin
              st_d[i]    = ST_ACTIVE;
              x_d[i]     = X_SPAWN_V;
              h_d[i]     = h_val;
              pulse_d[i] = 1'b1;
            end
          end
        endcase
      end
    end
  end

  // State registers; reset and clear both restore the opening layout.
  always_ff @(posedge clk) begin
    if (reset || clear) begin
      lfsr_q   <= LFSR_SEED;
      x_q[0]   <= X1_INIT;
      x_q[1]   <= X2_INIT;
      h_q[0]   <= H1_INIT;
      h_q[1]   <= H2_INIT;
      cnt_q[0] <= 8'd0;
      cnt_q[1] <= 8'd0;
      st_q[0]  <= ST_ACTIVE;
      st_q[1]  <= ST_ACTIVE;
      pulse_q  <= 2'b00;
    end else begin
      lfsr_q  <= lfsr_d;
      x_q     <= x_d;
      h_q     <= h_d;
      cnt_q   <= cnt_d;
      st_q    <= st_d;
      pulse_q <= pulse_d;
    end
  end

  assign obs1X       = x_q[0];
  assign obs1H       = h_q[0];
  assign obs2X       = x_q[1];
  assign obs2H       = h_q[1];
  // Slot state doubles as the externally visible FSM state.
  assign obs_active  = {st_q[1] == ST_ACTIVE, st_q[0] == ST_ACTIVE};
  assign spawn_pulse = pulse_q;

endmodule

// File: tb/tb_obstacle_spawner.sv
// Bench for obstacle_spawner: vector table, directed retire/respawn, block and
// clear-at-spawn sequences, then a randomized soak against a slot-level model.
module tb_obstacle_spawner;

  // ---------------- clock / reset ----------------
  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       clear = 1'b0;
  logic       run = 1'b0;
  logic       step = 1'b0;
  logic [7:0] obs1X, obs1H, obs2X, obs2H;
  logic [1:0] obs_active, spawn_pulse;

  always #5 clk = ~clk;

  obstacle_spawner dut (
    .clk(clk), .reset(reset), .clear(clear), .run(run), .step(step),
    .obs1X(obs1X), .obs1H(obs1H), .obs2X(obs2X), .obs2H(obs2H),
    .obs_active(obs_active), .spawn_pulse(spawn_pulse)
  );

  int checks = 0;
  int failures = 0;
  int block_events = 0;

  logic [35:0] exp_q[$];

  // ---------------- reference model ----------------
  // Slots as plain integers: position, height, active flag, remaining gap.
  int          m_x[2];
  int          m_h[2];
  bit          m_act[2];
  int          m_cnt[2];
  bit          m_sp[2];
  bit          m_blk[2];
  logic [15:0] m_lfsr;

  function automatic logic [15:0] lfsr_next(input logic [15:0] l);
    return l[0] ? ((l >> 1) ^ 16'hB400) : (l >> 1);
  endfunction

  task automatic model_init();
    m_x = '{120, 254};
    m_h = '{7, 14};
    m_act = '{1'b1, 1'b1};
    m_cnt = '{0, 0};
    m_sp = '{1'b0, 1'b0};
    m_blk = '{1'b0, 1'b0};
    m_lfsr = 16'hACE1;
  endtask

  task automatic model_edge(input logic rst, input logic clr, input logic ru, input logic st);
    int  view_x;
    bit  view_act;
    int  snap_x[2];
    bit  snap_act[2];
    if (rst || clr) begin
      model_init();
      return;
    end
    m_sp = '{1'b0, 1'b0};
    m_blk = '{1'b0, 1'b0};
    if (ru && st) begin
      snap_x = m_x;
      snap_act = m_act;
      for (int i = 0; i < 2; i++) begin
        // The other slot as seen before the advance, except that slot 2
        // sees a slot 1 that has just spawned.
        view_x = snap_x[1 - i];
        view_act = snap_act[1 - i];
        if (i == 1 && m_sp[0]) begin
          view_x = 160;
          view_act = 1'b1;
        end
        if (m_act[i]) begin
          if (m_x[i] == 0) begin
            m_act[i] = 1'b0;
            m_x[i] = 255;
            m_cnt[i] = 40 + ((int'(m_lfsr) >> 8) % 64);
          end else begin
            m_x[i] = m_x[i] - 1;
          end
        end else if (m_cnt[i] > 0) begin
          m_cnt[i] = m_cnt[i] - 1;
        end else if (view_act && view_x > 160 - 48) begin
          m_blk[i] = 1'b1;
        end else begin
          m_act[i] = 1'b1;
          m_x[i] = 160;
          m_h[i] = 7 + (int'(m_lfsr) % 8);
          m_sp[i] = 1'b1;
        end
      end
    end
    m_lfsr = lfsr_next(m_lfsr);
  endtask

  function automatic logic [35:0] model_vec();
    return {8'(m_x[0]), 8'(m_h[0]), 8'(m_x[1]), 8'(m_h[1]),
            m_act[1], m_act[0], m_sp[1], m_sp[0]};
  endfunction

  function automatic logic [35:0] dut_vec();
    return {obs1X, obs1H, obs2X, obs2H, obs_active, spawn_pulse};
  endfunction

  // ---------------- scoreboard ----------------
  task automatic check(input string name, input logic [35:0] actual, input logic [35:0] required);
    checks++;
    if (actual !== required) begin
      failures++;
      $display("FAIL %s actual=%h required=%h (t=%0t)", name, actual, required, $time);
    end
  endtask

  // ---------------- driver ----------------
  // Entered at a negedge: drive, take the edge, then compare at the next negedge.
  task automatic cycle(input logic rst, input logic clr, input logic ru, input logic st);
    reset = rst;
    clear = clr;
    run = ru;
    step = st;
    @(posedge clk);
    model_edge(rst, clr, ru, st);
    exp_q.push_back(model_vec());
    @(negedge clk);
    check("model_vec", dut_vec(), exp_q.pop_front());
    for (int i = 0; i < 2; i++) begin
      if (m_blk[i]) begin
        block_events++;
        check("blocked_park", {28'd0, (i == 0) ? obs1X : obs2X}, 36'd255);
        check("blocked_inactive", {35'd0, obs_active[i]}, 36'd0);
      end
    end
  endtask

  // From the opening layout: retire slot 1, then count steps to its respawn.
  task automatic retire_and_respawn(input string tag);
    int gap;
    int n;
    bit seen;
    for (int k = 0; k < 120; k++) cycle(1'b0, 1'b0, 1'b1, 1'b1);
    check({tag, "_x1_zero"}, {28'd0, obs1X}, 36'd0);
    check({tag, "_still_active"}, {34'd0, obs_active}, 36'd3);
    cycle(1'b0, 1'b0, 1'b1, 1'b1);
    check({tag, "_parked"}, {28'd0, obs1X}, 36'd255);
    check({tag, "_retired"}, {35'd0, obs_active[0]}, 36'd0);
    gap = m_cnt[0];
    n = 0;
    seen = 1'b0;
    while (!seen && n < 200) begin
      cycle(1'b0, 1'b0, 1'b1, 1'b1);
      n++;
      if (spawn_pulse[0]) seen = 1'b1;
    end
    check({tag, "_respawn_seen"}, {35'd0, seen}, 36'd1);
    check({tag, "_gap_steps"}, 36'(n), 36'(gap + 1));
    check({tag, "_gap_range"}, {35'd0, (n >= 41 && n <= 104)}, 36'd1);
    check({tag, "_spawn_x"}, {28'd0, obs1X}, 36'd160);
    check({tag, "_spawn_h_range"}, {35'd0, (obs1H >= 8'd7 && obs1H <= 8'd14)}, 36'd1);
    check({tag, "_spawn_h_model"}, {28'd0, obs1H}, 36'(m_h[0]));
    cycle(1'b0, 1'b0, 1'b1, 1'b0);
    check({tag, "_pulse_drop"}, {34'd0, spawn_pulse}, 36'd0);
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic       rst, clr, ru, st;
    logic [7:0] x1, h1, x2, h2;
    logic [1:0] act, sp;
  } vec_t;

  vec_t vecs[12];

  initial begin
    bit ok;
    int n;
    bit pend;
    bit run_r;
    logic rnd_clr;

    model_init();
    for (int k = 0; k < 12; k++)
      vecs[k] = '{1'b0, 1'b0, 1'b0, 1'b0, 8'd120, 8'd7, 8'd254, 8'd14, 2'b11, 2'b00};
    vecs[0].rst = 1'b1;
    for (int k = 4; k < 9; k++) vecs[k].st = 1'b1;
    vecs[9] = '{1'b0, 1'b0, 1'b1, 1'b1, 8'd119, 8'd7, 8'd253, 8'd14, 2'b11, 2'b00};
    vecs[10] = '{1'b0, 1'b0, 1'b1, 1'b0, 8'd119, 8'd7, 8'd253, 8'd14, 2'b11, 2'b00};
    vecs[11] = '{1'b0, 1'b0, 1'b0, 1'b1, 8'd119, 8'd7, 8'd253, 8'd14, 2'b11, 2'b00};

    @(negedge clk);
    for (int k = 0; k < 12; k++) begin
      cycle(vecs[k].rst, vecs[k].clr, vecs[k].ru, vecs[k].st);
      check($sformatf("table_%0d", k), dut_vec(),
            {vecs[k].x1, vecs[k].h1, vecs[k].x2, vecs[k].h2, vecs[k].act, vecs[k].sp});
    end

    // Retire and respawn of slot 1 from reset.
    cycle(1'b1, 1'b0, 1'b0, 1'b0);
    retire_and_respawn("reset");

    // Clear in the cycle slot 2 would spawn.
    cycle(1'b1, 1'b0, 1'b0, 1'b0);
    ok = 1'b0;
    n = 0;
    while (!ok && n < 1500) begin
      pend = !m_act[1] && m_cnt[1] == 0 && !(m_act[0] && m_x[0] > 112)
             && !(!m_act[0] && m_cnt[0] == 0);
      if (pend) ok = 1'b1;
      else cycle(1'b0, 1'b0, 1'b1, 1'b1);
      n++;
    end
    check("clr_pending_found", {35'd0, ok}, 36'd1);
    cycle(1'b0, 1'b1, 1'b1, 1'b1);
    check("clr_layout", dut_vec(), {8'd120, 8'd7, 8'd254, 8'd14, 2'b11, 2'b00});
    cycle(1'b0, 1'b0, 1'b1, 1'b0);
    check("clr_hold", dut_vec(), {8'd120, 8'd7, 8'd254, 8'd14, 2'b11, 2'b00});
    // Gap and height after clear depend only on the reloaded seed.
    cycle(1'b0, 1'b1, 1'b0, 1'b0);
    retire_and_respawn("clear");

    // Hunt for spawns held back by the separation rule, with jittered steps.
    cycle(1'b1, 1'b0, 1'b0, 1'b0);
    n = 0;
    while (block_events < 4 && n < 6000) begin
      cycle(1'b0, 1'b0, 1'b1, ($urandom_range(0, 7) != 0));
      n++;
    end
    if (block_events == 0) $display("note: no blocked spawn reached in hunt phase");

    // Randomized soak.
    run_r = 1'b1;
    for (int k = 0; k < 40000; k++) begin
      if ($urandom_range(0, 49) == 0) run_r = ~run_r;
      rnd_clr = ($urandom_range(0, 3999) == 0);
      cycle(1'b0, rnd_clr, run_r, 1'($urandom_range(0, 1)));
      if (spawn_pulse[0]) begin
        check("soak_h1_range", {35'd0, (obs1H >= 8'd7 && obs1H <= 8'd14)}, 36'd1);
        check("soak_sep1", {35'd0, (!obs_active[1] || obs2X <= 8'd112)}, 36'd1);
      end
      if (spawn_pulse[1]) begin
        check("soak_h2_range", {35'd0, (obs2H >= 8'd7 && obs2H <= 8'd14)}, 36'd1);
        check("soak_sep2", {35'd0, (!obs_active[0] || obs1X <= 8'd112)}, 36'd1);
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
